// File: rtl/tdm_mux_scan.sv
// Registered N-channel multiplexer with a valid/ready output stage.
// Emits one beat from a selected channel (manual) or one beat per enabled mask channel (scan).
module tdm_mux_scan #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              start,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

  logic [0:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [N_CH-1:0]  pick_src;
  logic [N_CH-1:0]  pick_onehot;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [SEL_W-1:0] load_idx;
  logic [W-1:0]     load_data;

  // A new scan picks from the live ch_mask; a running scan picks from the latched remainder.
  assign pick_src = (state_q == ST_IDLE) ? ch_mask : mask_q;

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (pick_src[c]) begin
        pick_found  = 1'b1;
        pick_idx    = SEL_W'(c);
        pick_onehot = '0;
        pick_onehot[c] = 1'b1;
      end
    end
  end

  assign load_idx = (state_q == ST_IDLE && !mode) ? sel : pick_idx;

  always_comb begin
    load_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (load_idx == SEL_W'(c)) load_data = in_data[c*W +: W];
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (!mode) begin
            if ({1'b0, sel} < N_CH_L) begin
              out_data_d = load_data;
              out_ch_d   = load_idx;
              state_d    = ST_XFER;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            mask_d = ch_mask;
            if (pick_found) begin
              out_data_d = load_data;
              out_ch_d   = load_idx;
              mask_d     = pick_src & ~pick_onehot;
              state_d    = ST_XFER;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (out_ready) begin
          if (mode_q && pick_found) begin
            out_data_d = load_data;
            out_ch_d   = load_idx;
            mask_d     = pick_src & ~pick_onehot;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      mask_q     <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = (state_q == ST_XFER);
  assign busy      = (state_q == ST_XFER);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Bench for tdm_mux_scan: table-driven manual beats, directed multi-cycle sequences,
// and a randomized run against a queue-based reference model.
module tb_tdm_mux_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: N_CH=8, W=1
  logic [7:0] a_in;
  logic       a_mode, a_start, a_ready;
  logic [2:0] a_sel;
  logic [7:0] a_mask;
  logic [0:0] a_data;
  logic [2:0] a_ch;
  logic       a_valid, a_busy, a_done, a_err;

  // Instance B: N_CH=6, W=3
  logic [17:0] b_in;
  logic        b_mode, b_start, b_ready;
  logic [2:0]  b_sel;
  logic [5:0]  b_mask;
  logic [2:0]  b_data;
  logic [2:0]  b_ch;
  logic        b_valid, b_busy, b_done, b_err;

  tdm_mux_scan #(.N_CH(8), .W(1), .SEL_W(3)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in), .mode(a_mode), .sel(a_sel),
    .ch_mask(a_mask), .start(a_start), .out_data(a_data), .out_ch(a_ch),
    .out_valid(a_valid), .out_ready(a_ready), .busy(a_busy), .done(a_done), .err(a_err)
  );

  tdm_mux_scan #(.N_CH(6), .W(3), .SEL_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in), .mode(b_mode), .sel(b_sel),
    .ch_mask(b_mask), .start(b_start), .out_data(b_data), .out_ch(b_ch),
    .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy), .done(b_done), .err(b_err)
  );

  typedef struct {
    logic [7:0] in;
    logic [2:0] sel;
    logic       exp_data;
  } man_vec_t;

  man_vec_t tbl[7];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int chan_val(input logic [17:0] v, input int c);
    return int'((v >> (c * 3)) & 18'h7);
  endfunction

  // Reference model state for the randomized run on instance B
  int q[$];
  bit m_busy;
  int m_ch, m_data;
  bit m_done, m_err;

  initial begin
    int busy_cnt, beats;
    int chs[4];
    bit saw_done;

    tbl[0] = '{8'b11100010, 3'd5, 1'b1};
    tbl[1] = '{8'b11100010, 3'd0, 1'b0};
    tbl[2] = '{8'b11100010, 3'd1, 1'b1};
    tbl[3] = '{8'b11100010, 3'd7, 1'b1};
    tbl[4] = '{8'b01010101, 3'd2, 1'b1};
    tbl[5] = '{8'b01010101, 3'd7, 1'b0};
    tbl[6] = '{8'b10000000, 3'd6, 1'b0};

    rst = 1'b1;
    a_in = '0; a_mode = 0; a_start = 0; a_ready = 1; a_sel = '0; a_mask = '0;
    b_in = '0; b_mode = 0; b_start = 0; b_ready = 1; b_sel = '0; b_mask = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_a_data", 32'(a_data), 0);
    check("rst_a_ch", 32'(a_ch), 0);
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_a_busy", 32'(a_busy), 0);
    check("rst_a_done", 32'(a_done), 0);
    check("rst_a_err", 32'(a_err), 0);
    check("rst_b_valid", 32'(b_valid), 0);

    // Manual single beats
    for (int i = 0; i < 7; i++) begin
      a_in = tbl[i].in; a_sel = tbl[i].sel; a_mode = 0; a_ready = 1; a_start = 1;
      tick();
      a_start = 0;
      check($sformatf("man%0d_valid", i), 32'(a_valid), 1);
      check($sformatf("man%0d_data", i), 32'(a_data), 32'(tbl[i].exp_data));
      check($sformatf("man%0d_ch", i), 32'(a_ch), 32'(tbl[i].sel));
      check($sformatf("man%0d_busy", i), 32'(a_busy), 1);
      tick();
      check($sformatf("man%0d_valid_end", i), 32'(a_valid), 0);
      check($sformatf("man%0d_done", i), 32'(a_done), 1);
      tick();
      check($sformatf("man%0d_done_clr", i), 32'(a_done), 0);
    end

    // Full scan at one beat per cycle
    a_in = 8'b11100010; a_mode = 1; a_mask = 8'hFF; a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("scan_valid%0d", k), 32'(a_valid), 1);
      check($sformatf("scan_ch%0d", k), 32'(a_ch), k);
      check($sformatf("scan_data%0d", k), 32'(a_data), 32'(a_in[k]));
      check($sformatf("scan_done_low%0d", k), 32'(a_done), 0);
      busy_cnt += int'(a_busy);
      tick();
    end
    check("scan_done", 32'(a_done), 1);
    check("scan_busy_end", 32'(a_busy), 0);
    check("scan_valid_end", 32'(a_valid), 0);
    check("scan_busy_cycles", busy_cnt, 8);
    tick();
    check("scan_done_clr", 32'(a_done), 0);

    // Backpressure stall with in_data toggling
    a_in = 8'b11100010; a_mode = 1; a_mask = 8'b10010100; a_ready = 0; a_start = 1;
    tick();
    a_start = 0;
    check("stall_ch_load", 32'(a_ch), 2);
    for (int k = 0; k < 3; k++) begin
      a_in = ~a_in;
      tick();
      check($sformatf("stall_valid%0d", k), 32'(a_valid), 1);
      check($sformatf("stall_ch%0d", k), 32'(a_ch), 2);
      check($sformatf("stall_data%0d", k), 32'(a_data), 0);
    end
    a_in = 8'b11100010; a_ready = 1;
    tick();
    check("stall_ch4", 32'(a_ch), 4);
    check("stall_data4", 32'(a_data), 0);
    tick();
    check("stall_ch7", 32'(a_ch), 7);
    check("stall_data7", 32'(a_data), 1);
    tick();
    check("stall_done", 32'(a_done), 1);
    check("stall_valid_end", 32'(a_valid), 0);

    // Empty mask, then start on the done cycle
    tick();
    a_mode = 1; a_mask = 8'h00; a_start = 1;
    tick();
    check("empty_done", 32'(a_done), 1);
    check("empty_valid", 32'(a_valid), 0);
    check("empty_busy", 32'(a_busy), 0);
    check("empty_err", 32'(a_err), 0);
    a_mode = 0; a_sel = 3'd6; a_in = 8'b01000000; a_ready = 0;
    tick();
    a_start = 0;
    check("ondone_valid", 32'(a_valid), 1);
    check("ondone_ch", 32'(a_ch), 6);
    check("ondone_data", 32'(a_data), 1);
    check("ondone_done_clr", 32'(a_done), 0);
    a_ready = 1;
    tick();
    check("ondone_done", 32'(a_done), 1);

    // Start while busy is ignored
    a_in = 8'b11100010; a_mode = 1; a_mask = 8'b00000011; a_ready = 0; a_start = 1;
    tick();
    a_mode = 0; a_sel = 3'd5; a_mask = 8'hFF;
    tick(); tick();
    a_start = 0;
    check("ignore_ch_held", 32'(a_ch), 0);
    a_ready = 1;
    beats = 0; saw_done = 0;
    for (int k = 0; k < 20 && !saw_done; k++) begin
      if (a_valid) begin
        if (beats < 4) chs[beats] = int'(a_ch);
        beats++;
      end
      tick();
      if (a_done) saw_done = 1;
    end
    check("ignore_done_seen", 32'(saw_done), 1);
    check("ignore_beats", beats, 2);
    check("ignore_ch_first", chs[0], 0);
    check("ignore_ch_second", chs[1], 1);
    tick();

    // Asynchronous reset mid-scan
    a_in = 8'b11100010; a_mode = 1; a_mask = 8'hFF; a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    tick(); tick(); tick();
    check("arst_pre_ch", 32'(a_ch), 3);
    #2 rst = 1'b1;
    #1;
    check("arst_data", 32'(a_data), 0);
    check("arst_ch", 32'(a_ch), 0);
    check("arst_valid", 32'(a_valid), 0);
    check("arst_busy", 32'(a_busy), 0);
    check("arst_done", 32'(a_done), 0);
    check("arst_err", 32'(a_err), 0);
    rst = 1'b0;
    a_start = 1;
    tick();
    a_start = 0;
    check("arst_restart_valid", 32'(a_valid), 1);
    check("arst_restart_ch", 32'(a_ch), 0);
    for (int k = 0; k < 8; k++) tick();
    check("arst_restart_done", 32'(a_done), 1);

    // Out-of-range manual select on the 6-channel instance
    b_mode = 0; b_sel = 3'd6; b_ready = 1; b_start = 1;
    tick();
    b_start = 0;
    check("b_err", 32'(b_err), 1);
    check("b_err_valid", 32'(b_valid), 0);
    check("b_err_busy", 32'(b_busy), 0);
    check("b_err_done", 32'(b_done), 0);
    tick();
    check("b_err_clr", 32'(b_err), 0);

    // Randomized run against the reference model
    m_busy = 0; m_ch = 0; m_data = 0; q = {};
    for (int cyc = 0; cyc < 400; cyc++) begin
      b_in    = 18'($urandom);
      b_start = ($urandom_range(3) == 0);
      b_mode  = 1'($urandom_range(1));
      b_sel   = 3'($urandom_range(7));
      b_mask  = 6'($urandom);
      b_ready = ($urandom_range(3) != 0);

      m_done = 0; m_err = 0;
      if (!m_busy) begin
        if (b_start) begin
          q = {};
          if (!b_mode) begin
            if (int'(b_sel) < 6) begin
              m_busy = 1; m_ch = int'(b_sel);
            end else begin
              m_err = 1;
            end
          end else begin
            for (int c = 0; c < 6; c++) if (b_mask[c]) q.push_back(c);
            if (q.size() == 0) m_done = 1;
            else begin
              m_ch = q.pop_front(); m_busy = 1;
            end
          end
          if (m_busy) m_data = chan_val(b_in, m_ch);
        end
      end else if (b_ready) begin
        if (q.size() > 0) begin
          m_ch = q.pop_front(); m_data = chan_val(b_in, m_ch);
        end else begin
          m_busy = 0; m_done = 1;
        end
      end

      tick();
      check($sformatf("rnd%0d_valid", cyc), 32'(b_valid), 32'(m_busy));
      check($sformatf("rnd%0d_busy", cyc), 32'(b_busy), 32'(m_busy));
      check($sformatf("rnd%0d_done", cyc), 32'(b_done), 32'(m_done));
      check($sformatf("rnd%0d_err", cyc), 32'(b_err), 32'(m_err));
      if (m_busy) begin
        check($sformatf("rnd%0d_ch", cyc), 32'(b_ch), m_ch);
        check($sformatf("rnd%0d_data", cyc), 32'(b_data), m_data);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
